// File: rtl/level_event_scheduler.sv
// rtl/level_event_scheduler.sv - per-channel level-to-pulse FSMs feeding a round-robin valid/ready event port
module level_event_scheduler #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_CH-1:0] level,
  input  logic            evt_ready,
  input  logic [N_CH-1:0] clr_overflow,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow
);

  typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_FIRE = 2'd1, CH_HELD = 2'd2} ch_state_e;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_VALID = 1'b1} out_state_e;

  ch_state_e       ch_state_q [N_CH];
  ch_state_e       ch_state_d [N_CH];
  logic [N_CH-1:0] fire;

  out_state_e      out_state_q, out_state_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] overflow_q, overflow_d;

  logic            handshake;
  logic [N_CH-1:0] hs_clear;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;

  // Channel FSM state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) ch_state_q[i] <= CH_IDLE;
    end else begin
      for (int i = 0; i < N_CH; i++) ch_state_q[i] <= ch_state_d[i];
    end
  end

  // Channel FSM next state: IDLE -> FIRE on level, FIRE lasts one cycle, HELD until level drops
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_state_d[i] = CH_IDLE;
      case (ch_state_q[i])
        CH_IDLE: ch_state_d[i] = level[i] ? CH_FIRE : CH_IDLE;
        CH_FIRE: ch_state_d[i] = level[i] ? CH_HELD : CH_IDLE;
        CH_HELD: ch_state_d[i] = level[i] ? CH_HELD : CH_IDLE;
        default: ch_state_d[i] = CH_IDLE;
      endcase
    end
  end

  // Channel FSM Moore output: one-cycle fire pulse per rising level
  always_comb begin
    fire = '0;
    for (int i = 0; i < N_CH; i++) fire[i] = (ch_state_q[i] == CH_FIRE);
  end

  // Round-robin search: first pending channel at or above rr_ptr, wrapping
  always_comb begin
    int unsigned     cand;
    logic [ID_W-1:0] cand_id;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    cand_id     = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand    = (int'(rr_ptr_q) + i) % N_CH;
      cand_id = ID_W'(cand);
      if (!grant_found && pending_q[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  // Handshake decode: which pending bit the consumer retires this cycle
  always_comb begin
    handshake = (out_state_q == OUT_VALID) && evt_ready;
    hs_clear  = '0;
    for (int i = 0; i < N_CH; i++) hs_clear[i] = handshake && (evt_id_q == ID_W'(i));
  end

  // Arbiter FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_state_q <= OUT_IDLE;
    else          out_state_q <= out_state_d;
  end

  // Arbiter next state: present a winner, hold it until accepted, then one bubble
  always_comb begin
    out_state_d = out_state_q;
    case (out_state_q)
      OUT_IDLE:  if (grant_found) out_state_d = OUT_VALID;
      OUT_VALID: if (handshake)   out_state_d = OUT_IDLE;
      default:   out_state_d = OUT_IDLE;
    endcase
  end

  // Arbiter Moore outputs and status flags
  always_comb begin
    evt_valid = (out_state_q == OUT_VALID);
    evt_id    = evt_id_q;
    pending   = pending_q;
    overflow  = overflow_q;
  end

  // Datapath next values: depth-1 event queue, sticky loss flags, winner id and pointer
  always_comb begin
    pending_d  = (pending_q & ~hs_clear) | fire;
    overflow_d = (overflow_q & ~clr_overflow) | (fire & pending_q & ~hs_clear);
    evt_id_d   = evt_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (out_state_q == OUT_IDLE && grant_found) evt_id_d = grant_id;
    if (handshake) rr_ptr_d = (evt_id_q == ID_W'(N_CH - 1)) ? '0 : evt_id_q + ID_W'(1);
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
      evt_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      evt_id_q   <= evt_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_level_event_scheduler.sv
// tb/tb_level_event_scheduler.sv - self-checking bench for level_event_scheduler
module tb_level_event_scheduler;
  localparam int N_CH = 4;
  localparam int ID_W = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_CH-1:0] level = '0;
  logic            evt_ready = 1'b0;
  logic [N_CH-1:0] clr_overflow = '0;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overflow;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: events are rising edges of the sampled level, each channel
  // holds at most one waiting event, and a single port serves them round-robin.
  logic [N_CH-1:0] m_prev, m_rise, m_pend, m_ovf;
  bit              m_valid;
  int              m_id, m_rr;

  level_event_scheduler #(.N_CH(N_CH), .ID_W(ID_W)) dut (
    .clock(clock), .reset_n(reset_n), .level(level), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_id(evt_id),
    .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_prev = '0; m_rise = '0; m_pend = '0; m_ovf = '0;
    m_valid = 0; m_id = 0; m_rr = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] retired, lost;
    bit hs, found;
    int w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    hs = m_valid && evt_ready;
    retired = '0;
    if (hs) retired[m_id] = 1'b1;
    lost = m_rise & m_pend & ~retired;
    found = 0; w = 0;
    if (!m_valid)
      for (int k = 0; k < N_CH; k++)
        if (!found && m_pend[(m_rr + k) % N_CH]) begin found = 1; w = (m_rr + k) % N_CH; end
    if (hs) begin m_valid = 0; m_rr = (m_id + 1) % N_CH; end
    else if (found) begin m_valid = 1; m_id = w; end
    m_pend = (m_pend & ~retired) | m_rise;
    m_ovf  = (m_ovf & ~clr_overflow) | lost;
    m_rise = level & ~m_prev;
    m_prev = level;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drain();
    level = '0; evt_ready = 1'b1; clr_overflow = '0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", evt_id); end
    n_cmp++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
    n_cmp++; if (overflow !== '0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0000", overflow); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", evt_valid); end
  endtask

  task automatic test_single_event();
    int nv, vcyc, vid;
    drain();
    nv = 0; vcyc = -1; vid = -1;
    level[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (evt_valid === 1'b1) begin nv++; vcyc = c; vid = evt_id; end
      if (c == 2) begin
        n_cmp++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL t1_pending_set: got %b want 0001", pending); end
      end
    end
    n_cmp++; if (nv != 1) begin n_fail++; $display("FAIL t1_valid_cycles: got %0d want 1", nv); end
    n_cmp++; if (vcyc != 3) begin n_fail++; $display("FAIL t1_latency: got %0d want 3", vcyc); end
    n_cmp++; if (vid != 0) begin n_fail++; $display("FAIL t1_id: got %0d want 0", vid); end
    n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t1_pending_clear: got %b want 0000", pending); end
  endtask

  task automatic test_round_robin();
    int ids[8], cyc[8];
    int nv;
    drain();
    nv = 0;
    level = 4'b1110;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (evt_valid === 1'b1 && nv < 8) begin ids[nv] = evt_id; cyc[nv] = c; nv++; end
    end
    n_cmp++; if (nv != 3) begin n_fail++; $display("FAIL t2_count: got %0d want 3", nv); end
    for (int j = 0; j < 3 && j < nv; j++) begin
      n_cmp++; if (ids[j] != j + 1) begin n_fail++; $display("FAIL t2_id%0d: got %0d want %0d", j, ids[j], j + 1); end
      n_cmp++; if (cyc[j] != 3 + 2 * j) begin n_fail++; $display("FAIL t2_cycle%0d: got %0d want %0d", j, cyc[j], 3 + 2 * j); end
    end
    drain();
    nv = 0;
    level = 4'b1001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (evt_valid === 1'b1 && nv < 8) begin ids[nv] = evt_id; cyc[nv] = c; nv++; end
    end
    n_cmp++; if (nv != 2) begin n_fail++; $display("FAIL t2_wrap_count: got %0d want 2", nv); end
    n_cmp++; if (nv > 0 && ids[0] != 0) begin n_fail++; $display("FAIL t2_wrap_first: got %0d want 0", ids[0]); end
    n_cmp++; if (nv > 1 && ids[1] != 3) begin n_fail++; $display("FAIL t2_wrap_second: got %0d want 3", ids[1]); end
  endtask

  task automatic test_backpressure();
    int waited;
    drain();
    evt_ready = 1'b0;
    level[2] = 1'b1;
    waited = 0;
    while (evt_valid !== 1'b1 && waited < 10) begin tick(); waited++; end
    n_cmp++; if (waited != 3) begin n_fail++; $display("FAIL t3_latency: got %0d want 3", waited); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL t3_hold_valid%0d: got %b want 1", c, evt_valid); end
      n_cmp++; if (evt_id !== 2'd2) begin n_fail++; $display("FAIL t3_hold_id%0d: got %0d want 2", c, evt_id); end
    end
    evt_ready = 1'b1;
    tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL t3_release: got %b want 0", evt_valid); end
    n_cmp++; if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL t3_pending: got %b want 0", pending[2]); end
  endtask

  task automatic test_overflow();
    int nhs;
    drain();
    evt_ready = 1'b0;
    level[0] = 1'b1;
    repeat (3) tick();
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin n_fail++; $display("FAIL t4_first: got valid %b id %0d want 1/0", evt_valid, evt_id); end
    level[0] = 1'b0; tick();
    level[0] = 1'b1; tick();
    tick();
    n_cmp++; if (overflow[0] !== 1'b1) begin n_fail++; $display("FAIL t4_overflow_set: got %b want 1", overflow[0]); end
    n_cmp++; if (overflow[3:1] !== 3'b000) begin n_fail++; $display("FAIL t4_overflow_others: got %b want 000", overflow[3:1]); end
    evt_ready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 10; c++) begin
      if (evt_valid === 1'b1 && evt_id === 2'd0) nhs++;
      tick();
    end
    n_cmp++; if (nhs != 1) begin n_fail++; $display("FAIL t4_delivered: got %0d want 1", nhs); end
    n_cmp++; if (overflow[0] !== 1'b1) begin n_fail++; $display("FAIL t4_sticky: got %b want 1", overflow[0]); end
    clr_overflow[0] = 1'b1; tick(); clr_overflow = '0;
    n_cmp++; if (overflow[0] !== 1'b0) begin n_fail++; $display("FAIL t4_clear: got %b want 0", overflow[0]); end
  endtask

  task automatic test_simultaneous();
    drain();
    evt_ready = 1'b0;
    level[1] = 1'b1;
    repeat (3) tick();
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_fail++; $display("FAIL t5_first: got valid %b id %0d want 1/1", evt_valid, evt_id); end
    level[1] = 1'b0; tick();
    level[1] = 1'b1; tick();
    evt_ready = 1'b1; tick();
    n_cmp++; if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL t5_pending: got %b want 1", pending[1]); end
    n_cmp++; if (overflow[1] !== 1'b0) begin n_fail++; $display("FAIL t5_overflow: got %b want 0", overflow[1]); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL t5_bubble: got %b want 0", evt_valid); end
    tick();
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin n_fail++; $display("FAIL t5_second: got valid %b id %0d want 1/1", evt_valid, evt_id); end
    tick();
    n_cmp++; if (pending[1] !== 1'b0) begin n_fail++; $display("FAIL t5_drained: got %b want 0", pending[1]); end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 3) == 0) level[ch] = ~level[ch];
      evt_ready = ($urandom_range(0, 2) != 0);
      clr_overflow = '0;
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 7) == 0) clr_overflow[ch] = 1'b1;
      tick();
      n_cmp++; if (evt_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, evt_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (evt_id !== ID_W'(m_id)) begin n_fail++; $display("FAIL rnd_id@%0d: got %0d want %0d", c, evt_id, m_id); end
      end
      n_cmp++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending@%0d: got %b want %b", c, pending, m_pend); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow, m_ovf); end
    end
    clr_overflow = '0;
  endtask

  task automatic test_reset_mid();
    int nhs, first;
    drain();
    evt_ready = 1'b0;
    level[3] = 1'b1;
    repeat (3) tick();
    n_cmp++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin n_fail++; $display("FAIL t6_presented: got valid %b id %0d want 1/3", evt_valid, evt_id); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL t6_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_id !== '0) begin n_fail++; $display("FAIL t6_id: got %0d want 0", evt_id); end
    n_cmp++; if (pending !== '0) begin n_fail++; $display("FAIL t6_pending: got %b want 0000", pending); end
    n_cmp++; if (overflow !== '0) begin n_fail++; $display("FAIL t6_overflow: got %b want 0000", overflow); end
    tick(); tick();
    reset_n = 1'b1;
    evt_ready = 1'b1;
    nhs = 0; first = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (evt_valid === 1'b1) begin
        if (first < 0) first = c;
        if (evt_id === 2'd3) nhs++;
      end
    end
    n_cmp++; if (first != 3) begin n_fail++; $display("FAIL t6_latency: got %0d want 3", first); end
    n_cmp++; if (nhs != 1) begin n_fail++; $display("FAIL t6_events: got %0d want 1", nhs); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
